// File: rtl/down_timer_if.sv
// down_timer_if: control inputs and status outputs of the down_timer block
interface down_timer_if #(parameter int WIDTH = 8);
   logic             EN;
   logic             CLR;
   logic             LOAD;
   logic             AUTO_RELOAD;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] counter;
   logic             UF;
   logic             busy;
   logic             done;
   modport master (output EN, CLR, LOAD, AUTO_RELOAD, load_value, input counter, UF, busy, done);
   modport slave (input EN, CLR, LOAD, AUTO_RELOAD, load_value, output counter, UF, busy, done);
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down counter with one-shot/periodic modes, pause and underflow pulse
module down_timer #(parameter int WIDTH = 8) (
   input logic        clk,
   input logic        Reset,
   down_timer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] reload;
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state       <= IDLE;
         reload      <= '0;
         bus.counter <= '0;
         bus.UF      <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else if (bus.CLR) begin
         state       <= IDLE;
         bus.counter <= '0;
         bus.UF      <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else if (bus.LOAD) begin
         state       <= (bus.load_value != '0) ? RUN : DONE;
         reload      <= bus.load_value;
         bus.counter <= bus.load_value;
         bus.UF      <= 1'b0;
         bus.busy    <= bus.load_value != '0;
         bus.done    <= bus.load_value == '0;
      end else begin
         bus.UF <= 1'b0;
         if (state == RUN || state == HOLD) begin
            if (!bus.EN) begin
               state <= HOLD;
            end else if (bus.counter != WIDTH'(1)) begin
               state       <= RUN;
               bus.counter <= bus.counter - WIDTH'(1);
            end else begin
               // terminal decrement: AUTO_RELOAD only matters on this cycle
               bus.UF      <= 1'b1;
               state       <= bus.AUTO_RELOAD ? RUN : DONE;
               bus.counter <= bus.AUTO_RELOAD ? reload : '0;
               bus.busy    <= bus.AUTO_RELOAD;
               bus.done    <= !bus.AUTO_RELOAD;
            end
         end
      end
   end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed and randomized checks of down_timer against a count-based reference model
module tb_down_timer;
   logic clk = 1'b0;
   logic Reset;
   int   errors = 0;
   int   checks = 0;
   logic [7:0] m_cnt, m_rld;
   logic       m_uf, m_busy, m_done;
   down_timer_if #(.WIDTH(8)) bus ();
   down_timer #(.WIDTH(8)) dut (.clk(clk), .Reset(Reset), .bus(bus));
   always #5 clk = ~clk;

   // reference: a timer is "armed" (busy) or "finished" (done); pausing needs no separate mode
   task automatic cycle();
      @(posedge clk);
      if (!Reset) begin
         m_cnt = 0; m_rld = 0; m_uf = 0; m_busy = 0; m_done = 0;
      end else if (bus.CLR) begin
         m_cnt = 0; m_uf = 0; m_busy = 0; m_done = 0;
      end else if (bus.LOAD) begin
         m_cnt = bus.load_value; m_rld = bus.load_value; m_uf = 0;
         m_busy = (bus.load_value != 0); m_done = (bus.load_value == 0);
      end else begin
         m_uf = 0;
         if (m_busy && bus.EN) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else begin
               m_uf = 1;
               if (bus.AUTO_RELOAD) m_cnt = m_rld;
               else begin m_cnt = 0; m_busy = 0; m_done = 1; end
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.EN = 0; bus.CLR = 0; bus.LOAD = 0; bus.AUTO_RELOAD = 0; bus.load_value = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      Reset = 0;
      cycle(); cycle();
      Reset = 1;
      cycle();
      checks++;
      if (bus.counter !== 8'd0 || bus.UF !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset: got cnt=%0d uf=%b busy=%b done=%b, want 0 0 0 0", bus.counter, bus.UF, bus.busy, bus.done);
      end
   endtask

   task automatic test_oneshot();
      logic [7:0] seq [6] = '{5, 4, 3, 2, 1, 0};
      bus.LOAD = 1; bus.load_value = 5; bus.EN = 1; bus.AUTO_RELOAD = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         bus.LOAD = 0; bus.load_value = 8'($urandom);
         checks++;
         if (i < 6 && (bus.counter !== seq[i] || bus.UF !== (i == 5))) begin
            errors++;
            $display("FAIL oneshot_seq[%0d]: got cnt=%0d uf=%b, want cnt=%0d uf=%b", i, bus.counter, bus.UF, seq[i], i == 5);
         end else if (i >= 6 && (bus.counter !== 8'd0 || bus.UF !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0)) begin
            errors++;
            $display("FAIL oneshot_done[%0d]: got cnt=%0d uf=%b busy=%b done=%b, want 0 0 0 1", i, bus.counter, bus.UF, bus.busy, bus.done);
         end
      end
   endtask

   task automatic test_periodic();
      logic [7:0] seq [9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
      bus.LOAD = 1; bus.load_value = 3; bus.EN = 1; bus.AUTO_RELOAD = 1;
      for (int i = 0; i < 9; i++) begin
         cycle();
         bus.LOAD = 0;
         checks++;
         if (bus.counter !== seq[i] || bus.UF !== (i > 0 && seq[i] == 3) || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL periodic[%0d]: got cnt=%0d uf=%b busy=%b done=%b, want cnt=%0d uf=%b busy=1 done=0",
                     i, bus.counter, bus.UF, bus.busy, bus.done, seq[i], i > 0 && seq[i] == 3);
         end
      end
   endtask

   task automatic test_hold();
      bus.LOAD = 1; bus.load_value = 6; bus.EN = 1; bus.AUTO_RELOAD = 0;
      cycle(); bus.LOAD = 0;
      cycle(); cycle();
      bus.EN = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (bus.counter !== 8'd4 || bus.busy !== 1'b1 || bus.UF !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got cnt=%0d busy=%b uf=%b, want 4 1 0", i, bus.counter, bus.busy, bus.UF);
         end
      end
      bus.EN = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (bus.counter !== 8'(3 - i) || bus.UF !== (i == 3)) begin
            errors++;
            $display("FAIL resume[%0d]: got cnt=%0d uf=%b, want cnt=%0d uf=%b", i, bus.counter, bus.UF, 3 - i, i == 3);
         end
      end
   endtask

   task automatic test_load_override();
      bus.LOAD = 1; bus.load_value = 4; bus.EN = 1; bus.AUTO_RELOAD = 0;
      cycle(); bus.LOAD = 0;
      cycle(); cycle(); cycle();
      bus.LOAD = 1; bus.load_value = 2;
      cycle();
      checks++;
      if (bus.counter !== 8'd2 || bus.UF !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL load_on_terminal: got cnt=%0d uf=%b busy=%b, want 2 0 1", bus.counter, bus.UF, bus.busy);
      end
      bus.CLR = 1; bus.load_value = 7;
      cycle();
      bus.CLR = 0; bus.LOAD = 0;
      checks++;
      if (bus.counter !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.UF !== 1'b0) begin
         errors++;
         $display("FAIL clr_over_load: got cnt=%0d busy=%b done=%b uf=%b, want 0 0 0 0", bus.counter, bus.busy, bus.done, bus.UF);
      end
      cycle();
      checks++;
      if (bus.counter !== 8'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores_en: got cnt=%0d busy=%b, want 0 0", bus.counter, bus.busy);
      end
   endtask

   task automatic test_zero_and_reset();
      bus.LOAD = 1; bus.load_value = 0; bus.EN = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         bus.LOAD = 0;
         checks++;
         if (bus.counter !== 8'd0 || bus.UF !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL load_zero[%0d]: got cnt=%0d uf=%b busy=%b done=%b, want 0 0 0 1", i, bus.counter, bus.UF, bus.busy, bus.done);
         end
      end
      bus.LOAD = 1; bus.load_value = 5;
      cycle(); bus.LOAD = 0;
      cycle(); cycle();
      checks++;
      if (bus.counter !== 8'd3) begin
         errors++;
         $display("FAIL pre_reset: got cnt=%0d, want 3", bus.counter);
      end
      Reset = 0;
      cycle();
      Reset = 1;
      checks++;
      if (bus.counter !== 8'd0 || bus.UF !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got cnt=%0d uf=%b busy=%b done=%b, want 0 0 0 0", bus.counter, bus.UF, bus.busy, bus.done);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bus.EN          = ($urandom_range(9) < 7);
         bus.LOAD        = ($urandom_range(19) == 0);
         bus.CLR         = ($urandom_range(59) == 0);
         bus.AUTO_RELOAD = $urandom_range(1);
         bus.load_value  = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
         Reset           = ($urandom_range(149) != 0);
         cycle();
         checks++;
         if (bus.counter !== m_cnt || bus.UF !== m_uf || bus.busy !== m_busy || bus.done !== m_done) begin
            errors++;
            $display("FAIL random[%0d]: got cnt=%0d uf=%b busy=%b done=%b, want cnt=%0d uf=%b busy=%b done=%b",
                     i, bus.counter, bus.UF, bus.busy, bus.done, m_cnt, m_uf, m_busy, m_done);
         end
      end
      Reset = 1;
      idle_inputs();
   endtask

   initial begin
      Reset = 0;
      idle_inputs();
      test_reset();
      test_oneshot();
      test_periodic();
      test_hold();
      test_load_override();
      test_zero_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the count, reload register and load_value.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 Reset  input  1  reset, synchronous, active-low.
REQ-004 EN  input  1  count enable; decrement permitted when high.
REQ-005 CLR  input  1  synchronous clear of count and state machine.
REQ-006 LOAD  input  1  one-cycle strobe; captures load_value and starts a countdown.
REQ-007 load_value  input  WIDTH  start and reload value.
REQ-008 AUTO_RELOAD  input  1  1 = periodic mode, 0 = one-shot mode; sampled on each terminal decrement.
REQ-009 counter  output  WIDTH  current count, registered.
REQ-010 UF  output  1  underflow pulse, registered, high for exactly one cycle per terminal decrement.
REQ-011 busy  output  1  high in RUN or HOLD, registered.
REQ-012 done  output  1  high in DONE, registered.

Function
REQ-013 The block SHALL implement states IDLE, RUN, HOLD, DONE, with one state register and registered outputs.
REQ-014 Per-cycle priority SHALL be Reset > CLR > LOAD > EN-driven activity.
REQ-015 CLR SHALL set counter=0, UF=0 and state=IDLE, and SHALL leave the reload register unchanged.
REQ-016 LOAD with load_value!=0, in any state, SHALL set counter and the reload register to load_value, set state=RUN and set UF=0.
REQ-017 LOAD with load_value==0 SHALL set counter=0 and reload register=0, set state=DONE, and SHALL NOT assert UF.
REQ-018 RUN, EN=1, counter>1: counter SHALL decrement by 1; state stays RUN.
REQ-019 RUN, EN=1, counter==1, AUTO_RELOAD=0 (terminal decrement): next cycle SHALL show counter=0, UF=1, state=DONE.
REQ-020 RUN, EN=1, counter==1, AUTO_RELOAD=1 (terminal decrement): next cycle SHALL show counter=reload register, UF=1, state=RUN; counter never displays 0 in this mode.
REQ-021 RUN, EN=0: state SHALL go to HOLD; counter is held.
REQ-022 HOLD, EN=0: state stays HOLD; counter is held.
REQ-023 HOLD, EN=1: state SHALL return to RUN, and the decrement rules of REQ-018 to REQ-020 SHALL apply in that same cycle.
REQ-024 In IDLE and DONE, EN SHALL be ignored; the state persists until LOAD, CLR or Reset.
REQ-025 UF SHALL be 0 in every cycle not immediately following a terminal decrement.
REQ-026 A LOAD or CLR coincident with a terminal decrement SHALL win; no UF is produced.
REQ-027 In periodic mode, UF SHALL assert once every N enabled cycles for reload value N.
REQ-028 Decrement SHALL never wrap below 0, since counter==0 is only reachable in IDLE or DONE.
REQ-029 load_value and AUTO_RELOAD changes outside the LOAD and terminal-decrement cycles SHALL have no effect.

Reset
REQ-030 While Reset=0 at posedge clk: counter=0, reload register=0, state=IDLE, UF=0, busy=0, done=0.
REQ-031 Reset SHALL take effect mid-countdown in any state, with no UF emitted.
REQ-032 Reset SHALL NOT be in the sensitivity of any always block; it is sampled on clk only.

Verification
REQ-033 Reset low for 2 cycles, then high with inputs idle -> counter=0, busy=0, done=0, UF=0, state IDLE.
REQ-034 LOAD with load_value=5, AUTO_RELOAD=0, EN=1 -> counter 5,4,3,2,1,0; UF high only on the counter=0 cycle; then done=1 and busy=0, held for 10 further cycles.
REQ-035 LOAD with load_value=3, AUTO_RELOAD=1, EN=1 -> counter 3,2,1,3,2,1,3; UF high on each return to 3 (every 3 cycles); done stays 0.
REQ-036 LOAD with load_value=6 and EN=1, after 2 decrements drive EN=0 for 3 cycles -> counter holds 4 with busy=1 (HOLD); with EN=1 again -> 3,2,1,0 then UF.
REQ-037 LOAD with load_value=4 counting to 1, then LOAD with load_value=2 on the terminal cycle -> no UF, counter=2, RUN; CLR asserted together with LOAD -> counter=0, IDLE.
REQ-038 LOAD with load_value=0 -> DONE, counter=0, UF never asserted; Reset pulled low at counter=3 in RUN -> next cycle counter=0, IDLE, UF=0.
